// File: rtl/coef_loader_fsm.sv
// Copies one coefficient bank from a synchronous ROM into the FIR coefficient RAM, with a handshake, abort and per-bank valid flags.
// Define COEF_CHECKSUM_EN to add a running modulo-2^COEF_WIDTH sum of the written words on checksum.
module coef_loader_fsm #(
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 62,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_W     = 1,
    parameter int ROM_AW     = 7,
    parameter int RAM_AW     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BANK_W-1:0]     bank_sel,
    input  logic                  reverse,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_rd,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [COEF_WIDTH-1:0] rom_q,
    output logic                  ram_wren,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [COEF_WIDTH-1:0] ram_data,
    output logic [BANK_W-1:0]     ram_bank,
    output logic [NUM_BANKS-1:0]  coef_valid,
    output logic [COEF_WIDTH-1:0] checksum
);
    typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, FINISH} state_t;

    localparam logic [RAM_AW-1:0] LAST_TAP   = RAM_AW'(NUM_TAPS - 1);
    localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

    state_t                 state, state_next;
    logic [BANK_W-1:0]      bank;
    logic                   rev;
    logic [RAM_AW-1:0]      tap;
    logic [NUM_BANKS-1:0]   bank_mask;
    logic                   accept;
    logic                   last_tap;

    // Extra MSB keeps the compare exact when NUM_BANKS == 2^BANK_W.
    assign accept   = start && ({1'b0, bank_sel} < BANK_LIMIT);
    assign last_tap = (tap == LAST_TAP);
    assign ram_bank = bank;

    always_comb begin
        bank_mask = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_mask[b] = (bank == BANK_W'(b));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        rom_rd     = 1'b0;
        ram_wren   = 1'b0;
        ram_data   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_next = SETUP;
            end
            SETUP: state_next = abort ? IDLE : READ;
            READ: begin
                rom_rd     = 1'b1;
                state_next = abort ? IDLE : WRITE;
            end
            WRITE: begin
                // abort suppresses the write in the same cycle, including the last tap
                ram_data = rom_q;
                ram_wren = !abort;
                if (abort)         state_next = IDLE;
                else if (last_tap) state_next = FINISH;
                else               state_next = READ;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank       <= '0;
            rev        <= 1'b0;
            tap        <= '0;
            rom_addr   <= '0;
            ram_addr   <= '0;
            coef_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bank <= bank_sel;
                        rev  <= reverse;
                        tap  <= '0;
                    end
                end
                SETUP: begin
                    rom_addr   <= ROM_AW'(bank) * ROM_AW'(NUM_TAPS);
                    ram_addr   <= rev ? LAST_TAP : '0;
                    coef_valid <= coef_valid & ~bank_mask;
                end
                WRITE: begin
                    // Addresses stop on the last tap so they never leave the bank window.
                    if (!abort && !last_tap) begin
                        tap      <= tap + 1'b1;
                        rom_addr <= rom_addr + 1'b1;
                        ram_addr <= rev ? ram_addr - 1'b1 : ram_addr + 1'b1;
                    end
                end
                FINISH: coef_valid <= coef_valid | bank_mask;
                default: ;
            endcase
        end
    end

`ifdef COEF_CHECKSUM_EN
    logic [COEF_WIDTH-1:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (state == SETUP) begin
            sum <= '0;
        end else if (ram_wren) begin
            sum <= sum + ram_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule
